// File: rtl/seg7_scan_ctrl.sv
// Scan controller sharing one 7-segment bus between the units and tenths digits.
// New digit pairs are accepted by handshake and take effect only at frame boundaries.
module seg7_scan_ctrl #(
   parameter int DIGIT_CYCLES = 13500,
   parameter int BLANK_CYCLES = 270
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       upd_valid,
   output logic       upd_ready,
   input  logic [3:0] bcd_u,
   input  logic [3:0] bcd_d,
   output logic [6:0] seg,
   output logic [1:0] dig_en,
   output logic       frame_done
);

   localparam int MAX_LEN = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
   localparam int CW      = $clog2(MAX_LEN);
   localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {BLANK_U, SHOW_U, BLANK_D, SHOW_D} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt, last_cnt;
   logic [3:0]    shadow_u, shadow_d, pend_u, pend_d;

   function automatic logic [6:0] dec7(input logic [3:0] code);
      case (code)
         4'd0:    dec7 = 7'b0111111;
         4'd1:    dec7 = 7'b0000110;
         4'd2:    dec7 = 7'b1011011;
         4'd3:    dec7 = 7'b1001111;
         4'd4:    dec7 = 7'b1100110;
         4'd5:    dec7 = 7'b1101101;
         4'd6:    dec7 = 7'b1111101;
         4'd7:    dec7 = 7'b0000111;
         4'd8:    dec7 = 7'b1111111;
         4'd9:    dec7 = 7'b1101111;
         default: dec7 = 7'b1000000;
      endcase
   endfunction

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CW'(1);
      last_cnt  = (state == SHOW_U || state == SHOW_D) ? DIGIT_LAST : BLANK_LAST;
      if (cnt == last_cnt) begin
         cnt_nxt = '0;
         case (state)
            BLANK_U: state_nxt = SHOW_U;
            SHOW_U:  state_nxt = BLANK_D;
            BLANK_D: state_nxt = SHOW_D;
            default: state_nxt = BLANK_U;
         endcase
      end
   end

   // Outputs are computed from the next phase so they switch on the edge entering it.
   // upd_ready low doubles as the "pair pending" flag; apply happens on the frame_done cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= BLANK_U;
         cnt        <= '0;
         seg        <= '0;
         dig_en     <= 2'b00;
         frame_done <= 1'b0;
         upd_ready  <= 1'b1;
         shadow_u   <= '0;
         shadow_d   <= '0;
         pend_u     <= '0;
         pend_d     <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         frame_done <= (state_nxt == SHOW_D) && (cnt_nxt == DIGIT_LAST);
         case (state_nxt)
            SHOW_U: begin
               dig_en <= 2'b01;
               seg    <= dec7(shadow_u);
            end
            SHOW_D: begin
               dig_en <= 2'b10;
               seg    <= dec7(shadow_d);
            end
            default: begin
               dig_en <= 2'b00;
               seg    <= '0;
            end
         endcase
         if (upd_valid && upd_ready) begin
            pend_u    <= bcd_u;
            pend_d    <= bcd_d;
            upd_ready <= 1'b0;
         end else if (frame_done && !upd_ready) begin
            shadow_u  <= pend_u;
            shadow_d  <= pend_d;
            upd_ready <= 1'b1;
         end
      end
   end

endmodule
